// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
//   SEG_OFF    : active-low pattern with every segment unlit
//   SEG_HEX    : active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   seg_decode : nibble -> active-low segment pattern
//   idx_width  : width of a digit index for a given digit count (at least 1)
package sevenseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to seven-segment decoder (active-low patterns).
//   nibble_i : hex digit 0..F
//   seg_o    : {g,f,e,d,c,b,a}, 0 = segment lit
module hex_seg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(nibble_i);

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit seven-segment display driver.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   enable    : 0 = display dark, scan frozen
//   load      : capture value/dp_in/blank_in into the shadow registers
//   value     : hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp_in     : decimal point request per digit
//   blank_in  : force digit dark
//   segments  : {g,f,e,d,c,b,a} at configured polarity
//   dp        : decimal point at configured polarity
//   anodes    : one-hot digit enable at configured polarity
//   digit_idx : digit currently driven (aligned with anodes)
// All outputs are registered and reflect the state of the previous cycle.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned GAP_CYCLES     = 500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          LZ_SUPPRESS    = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                load,
  input  logic [4*N_DIGITS-1:0]               value,
  input  logic [N_DIGITS-1:0]                 dp_in,
  input  logic [N_DIGITS-1:0]                 blank_in,
  output logic [6:0]                          segments,
  output logic                                dp,
  output logic [N_DIGITS-1:0]                 anodes,
  output logic [idx_width(N_DIGITS)-1:0]      digit_idx
);

  localparam int unsigned IdxW = idx_width(N_DIGITS);
  localparam int unsigned PreW = $clog2(SCAN_DIV);

  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [PreW-1:0] GapEnd  = PreW'(GAP_CYCLES);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N_DIGITS - 1);

  // Pin levels for "unlit" / "inactive" at the configured polarity.
  localparam logic [6:0]          SegUnlit = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic                DpUnlit  = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AnOff    = {N_DIGITS{AN_ACTIVE_LOW}};

  // Shadow registers: the display logic never looks at the live inputs.
  logic [N_DIGITS-1:0][3:0] value_shadow_q;
  logic [N_DIGITS-1:0]      dp_shadow_q;
  logic [N_DIGITS-1:0]      blank_shadow_q;

  // Scan state.
  logic [PreW-1:0] pre_q, pre_d;
  logic [IdxW-1:0] idx_q, idx_d;

  // Output registers.
  logic [6:0]          seg_out_q, seg_out_d;
  logic                dp_out_q, dp_out_d;
  logic [N_DIGITS-1:0] an_out_q, an_out_d;
  logic [IdxW-1:0]     idx_out_q;

  // Decode path signals.
  logic [N_DIGITS-1:0] lead_zero;
  logic                zero_run;
  logic [3:0]          nib_sel;
  logic [6:0]          dec_seg;
  logic                active;
  logic                dark;
  logic                lit;
  logic [6:0]          seg_al;
  logic                dp_al;
  logic [N_DIGITS-1:0] an_hi;

  // ---------------------------------------------------------------------------
  // Shadow capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_shadow_q <= '0;
      dp_shadow_q    <= '0;
      blank_shadow_q <= '0;
    end else if (load) begin
      value_shadow_q <= value;
      dp_shadow_q    <= dp_in;
      blank_shadow_q <= blank_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler and digit index; both freeze while enable is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (enable) begin
      if (pre_q == PreLast) begin
        pre_d = '0;
        idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero mask: lead_zero[i] is set when nibbles i..N_DIGITS-1 are all 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (value_shadow_q[i] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  assign nib_sel = value_shadow_q[idx_q];

  hex_seg_decode u_dec (
    .nibble_i (nib_sel),
    .seg_o    (dec_seg)
  );

  // ---------------------------------------------------------------------------
  // Output next-state. A dark digit keeps its anode so the scan duty stays even.
  // ---------------------------------------------------------------------------
  always_comb begin
    active = enable && (pre_q >= GapEnd);
    dark   = blank_shadow_q[idx_q] ||
             (LZ_SUPPRESS && (idx_q != '0) && lead_zero[idx_q]);
    lit    = active && !dark;

    seg_al = lit ? dec_seg : SEG_OFF;
    dp_al  = !(lit && dp_shadow_q[idx_q]);

    an_hi = '0;
    if (active) begin
      an_hi[idx_q] = 1'b1;
    end

    seg_out_d = SEG_ACTIVE_LOW ? seg_al : ~seg_al;
    dp_out_d  = SEG_ACTIVE_LOW ? dp_al : ~dp_al;
    an_out_d  = AN_ACTIVE_LOW ? ~an_hi : an_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out_q <= SegUnlit;
      dp_out_q  <= DpUnlit;
      an_out_q  <= AnOff;
      idx_out_q <= '0;
    end else begin
      seg_out_q <= seg_out_d;
      dp_out_q  <= dp_out_d;
      an_out_q  <= an_out_d;
      idx_out_q <= idx_q;
    end
  end

  assign segments  = seg_out_q;
  assign dp        = dp_out_q;
  assign anodes    = an_out_q;
  assign digit_idx = idx_out_q;

endmodule
